// File: rtl/hann_frame_ctrl.sv
// Hanning windowing sequencer: issues window ROM indices, aligns samples with
// coefficients at the multiplier and tags windowed results for the FFT stage.
module hann_frame_ctrl #(
  parameter int unsigned IDX_W   = 10,
  parameter int unsigned ROM_LAT = 1,
  parameter int unsigned MUL_LAT = 1,
  parameter int unsigned FCNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [FCNT_W-1:0] num_frames,
  input  logic              in_valid,
  input  logic [15:0]       in_data,
  output logic              in_ready,
  output logic [IDX_W-1:0]  win_index,
  output logic [15:0]       mul_data,
  input  logic [15:0]       mul_result,
  output logic              out_valid,
  output logic [15:0]       out_data,
  output logic              out_first,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  localparam int unsigned    PIPE       = ROM_LAT + MUL_LAT;
  localparam int unsigned    DCW        = $clog2(PIPE + 1);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(PIPE - 1);
  localparam int unsigned    DBITS      = ROM_LAT * 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t                   state;
  state_t                   state_nxt;
  logic [IDX_W-1:0]         sample_idx;
  logic [FCNT_W-1:0]        frame_cnt;
  logic [FCNT_W-1:0]        frame_cnt_inc;
  logic [FCNT_W-1:0]        num_frames_q;
  logic [DCW-1:0]           drain_cnt;
  logic [PIPE-1:0]          vld_pipe;
  logic [PIPE-1:0]          first_pipe;
  logic [PIPE-1:0]          last_pipe;
  logic [ROM_LAT-1:0][15:0] data_pipe;
  logic [15:0]              data_head;
  logic                     accept;
  logic                     idx_last;
  logic                     frame_end;

  assign accept        = in_valid & in_ready;
  assign idx_last      = (sample_idx == '1);
  assign frame_cnt_inc = frame_cnt + 1'b1;
  assign frame_end     = accept & idx_last & (frame_cnt_inc == num_frames_q);
  // Head stage holds the last accepted sample so gaps do not disturb alignment.
  assign data_head     = accept ? in_data : data_pipe[0];

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt = (num_frames == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (frame_end) begin
          state_nxt = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == DRAIN_LAST) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      sample_idx   <= '0;
      frame_cnt    <= '0;
      num_frames_q <= '0;
      drain_cnt    <= '0;
      win_index    <= '0;
      vld_pipe     <= '0;
      first_pipe   <= '0;
      last_pipe    <= '0;
      data_pipe    <= '0;
      out_data     <= '0;
    end else begin
      state <= state_nxt;

      if (state == S_IDLE && start) begin
        num_frames_q <= num_frames;
        sample_idx   <= '0;
        frame_cnt    <= '0;
      end else if (accept) begin
        win_index  <= sample_idx;
        sample_idx <= sample_idx + 1'b1;
        if (idx_last) begin
          frame_cnt <= frame_cnt_inc;
        end
      end

      drain_cnt <= (state == S_DRAIN) ? drain_cnt + 1'b1 : '0;

      vld_pipe   <= {vld_pipe[PIPE-2:0], accept};
      first_pipe <= {first_pipe[PIPE-2:0], accept & (sample_idx == '0)};
      last_pipe  <= {last_pipe[PIPE-2:0], accept & idx_last};
      data_pipe  <= DBITS'({data_pipe, data_head});

      if (vld_pipe[PIPE-2]) begin
        out_data <= mul_result;
      end
    end
  end

  assign mul_data  = data_pipe[ROM_LAT-1];
  assign out_valid = vld_pipe[PIPE-1];
  assign out_first = first_pipe[PIPE-1];
  assign out_last  = last_pipe[PIPE-1];

endmodule
